// File: rtl/ball_track_ctrl.sv
// Frame-rate ball track qualifier: samples the detector hotbox once per frame,
// runs SEARCH/CONFIRM/TRACK/COAST and owns the debounced overlay enable.
module ball_track_ctrl #(
  parameter int V_END_LINE      = 515,
  parameter int MAX_JUMP        = 4,
  parameter int CONFIRM_FRAMES  = 3,
  parameter int LOST_FRAMES     = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit OVERLAY_DEFAULT = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] VGA_V_CNT,
  input  logic [12:0] VGA_H_CNT,
  input  logic [5:0]  BALL_X,
  input  logic [5:0]  BALL_Y,
  input  logic        KEY_N,
  output logic        DET_ENABLE,
  output logic        FRAME_TICK,
  output logic [5:0]  TRACK_X,
  output logic [5:0]  TRACK_Y,
  output logic        TRACK_VALID,
  output logic [6:0]  VEL_X,
  output logic [6:0]  VEL_Y,
  output logic        LOST,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CONFIRM = 2'd1,
    S_TRACK   = 2'd2,
    S_COAST   = 2'd3
  } state_e;

  localparam logic [12:0] V_END  = 13'(V_END_LINE);
  localparam logic [6:0]  JMP1   = 7'(MAX_JUMP);
  localparam logic [6:0]  JMP2   = 7'(2 * MAX_JUMP);
  localparam logic [3:0]  CONF_N = 4'(CONFIRM_FRAMES);
  localparam logic [4:0]  LOST_N = 5'(LOST_FRAMES);
  localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES - 1);

  logic unused_h;
  assign unused_h = ^VGA_H_CNT;

  // frame boundary detect
  logic eq_q, eq_d, eq_prev_q, eq_prev_d, tick;

  // button path
  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic        key_q, key_d, press;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic        pending_q, pending_d;

  // tracker state
  state_e      state_q, state_d;
  logic [5:0]  cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic [4:0]  miss_cnt_q, miss_cnt_d, miss_inc;
  logic [5:0]  track_x_q, track_x_d, track_y_q, track_y_d;
  logic [6:0]  vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic        valid_q, valid_d, lost_q, lost_d, tick_q, tick_d;
  logic        det_en_q, det_en_d;
  logic        miss;

  function automatic logic near(input logic [5:0] ax, input logic [5:0] ay,
                                input logic [5:0] bx, input logic [5:0] by,
                                input logic [6:0] d);
    logic [6:0] dx, dy;
    dx = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
    dy = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
    return (dx <= d) && (dy <= d);
  endfunction

  assign tick = eq_q & ~eq_prev_q;
  assign miss = ((BALL_X == 6'd0) && (BALL_Y == 6'd0)) || (BALL_X > 6'd39) || (BALL_Y > 6'd29);
  assign cnt_inc  = cnt_q + 4'd1;
  assign miss_inc = miss_cnt_q + 5'd1;

  // Counter restarts whenever the synchronised level returns to the accepted
  // one, so any bounce reloads it.
  always_comb begin
    eq_d      = (VGA_V_CNT == V_END);
    eq_prev_d = eq_q;
    sync1_d   = KEY_N;
    sync2_d   = sync1_q;
    key_d     = key_q;
    deb_cnt_d = '0;
    press     = 1'b0;
    if (sync2_q != key_q) begin
      if (deb_cnt_q == DB_MAX) begin
        key_d = sync2_q;
        press = ~sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 20'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    cnt_d      = cnt_q;
    miss_cnt_d = miss_cnt_q;
    track_x_d  = track_x_q;
    track_y_d  = track_y_q;
    vel_x_d    = vel_x_q;
    vel_y_d    = vel_y_q;
    valid_d    = valid_q;
    lost_d     = 1'b0;
    tick_d     = 1'b0;
    det_en_d   = det_en_q;
    pending_d  = pending_q ^ press;
    if (tick) begin
      tick_d    = 1'b1;
      det_en_d  = det_en_q ^ pending_q;
      // a press landing on the tick edge is held for the next frame
      pending_d = press;
      unique case (state_q)
        S_SEARCH: begin
          if (!miss) begin
            cand_x_d = BALL_X;
            cand_y_d = BALL_Y;
            cnt_d    = 4'd1;
            state_d  = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (miss) begin
            state_d = S_SEARCH;
          end else if (near(BALL_X, BALL_Y, cand_x_q, cand_y_q, JMP1)) begin
            cnt_d    = cnt_inc;
            cand_x_d = BALL_X;
            cand_y_d = BALL_Y;
            if (cnt_inc == CONF_N) begin
              state_d    = S_TRACK;
              track_x_d  = BALL_X;
              track_y_d  = BALL_Y;
              vel_x_d    = {1'b0, BALL_X} - {1'b0, cand_x_q};
              vel_y_d    = {1'b0, BALL_Y} - {1'b0, cand_y_q};
              valid_d    = 1'b1;
              miss_cnt_d = '0;
            end
          end else begin
            cand_x_d = BALL_X;
            cand_y_d = BALL_Y;
            cnt_d    = 4'd1;
          end
        end
        S_TRACK: begin
          if (!miss && near(BALL_X, BALL_Y, track_x_q, track_y_q, JMP1)) begin
            vel_x_d   = {1'b0, BALL_X} - {1'b0, track_x_q};
            vel_y_d   = {1'b0, BALL_Y} - {1'b0, track_y_q};
            track_x_d = BALL_X;
            track_y_d = BALL_Y;
          end else begin
            state_d    = S_COAST;
            miss_cnt_d = 5'd1;
          end
        end
        S_COAST: begin
          // reacquire window is twice the tracking window
          if (!miss && near(BALL_X, BALL_Y, track_x_q, track_y_q, JMP2)) begin
            state_d    = S_TRACK;
            vel_x_d    = {1'b0, BALL_X} - {1'b0, track_x_q};
            vel_y_d    = {1'b0, BALL_Y} - {1'b0, track_y_q};
            track_x_d  = BALL_X;
            track_y_d  = BALL_Y;
            miss_cnt_d = '0;
          end else if (miss_inc >= LOST_N) begin
            state_d    = S_SEARCH;
            valid_d    = 1'b0;
            track_x_d  = '0;
            track_y_d  = '0;
            vel_x_d    = '0;
            vel_y_d    = '0;
            miss_cnt_d = '0;
            lost_d     = 1'b1;
          end else begin
            miss_cnt_d = miss_inc;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      eq_q       <= 1'b0;
      eq_prev_q  <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      key_q      <= 1'b1;
      deb_cnt_q  <= '0;
      pending_q  <= 1'b0;
      state_q    <= S_SEARCH;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      cnt_q      <= '0;
      miss_cnt_q <= '0;
      track_x_q  <= '0;
      track_y_q  <= '0;
      vel_x_q    <= '0;
      vel_y_q    <= '0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
      tick_q     <= 1'b0;
      det_en_q   <= OVERLAY_DEFAULT;
    end else begin
      eq_q       <= eq_d;
      eq_prev_q  <= eq_prev_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      key_q      <= key_d;
      deb_cnt_q  <= deb_cnt_d;
      pending_q  <= pending_d;
      state_q    <= state_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      cnt_q      <= cnt_d;
      miss_cnt_q <= miss_cnt_d;
      track_x_q  <= track_x_d;
      track_y_q  <= track_y_d;
      vel_x_q    <= vel_x_d;
      vel_y_q    <= vel_y_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
      tick_q     <= tick_d;
      det_en_q   <= det_en_d;
    end
  end

  assign DET_ENABLE  = det_en_q;
  assign FRAME_TICK  = tick_q;
  assign TRACK_X     = track_x_q;
  assign TRACK_Y     = track_y_q;
  assign TRACK_VALID = valid_q;
  assign VEL_X       = vel_x_q;
  assign VEL_Y       = vel_y_q;
  assign LOST        = lost_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_ball_track_ctrl.sv
// Bench for ball_track_ctrl: directed frames plus a random ball walk, all
// checked against a frame-level reference model.
module tb_ball_track_ctrl;
  localparam int V_END = 515;

  logic        CLK = 1'b0;
  logic        RST;
  logic [12:0] VGA_V_CNT, VGA_H_CNT;
  logic [5:0]  BALL_X, BALL_Y;
  logic        KEY_N;
  logic        DET_ENABLE, FRAME_TICK, TRACK_VALID, LOST;
  logic [5:0]  TRACK_X, TRACK_Y;
  logic [6:0]  VEL_X, VEL_Y;
  logic [1:0]  STATE;

  ball_track_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .VGA_V_CNT(VGA_V_CNT), .VGA_H_CNT(VGA_H_CNT),
    .BALL_X(BALL_X), .BALL_Y(BALL_Y), .KEY_N(KEY_N),
    .DET_ENABLE(DET_ENABLE), .FRAME_TICK(FRAME_TICK),
    .TRACK_X(TRACK_X), .TRACK_Y(TRACK_Y), .TRACK_VALID(TRACK_VALID),
    .VEL_X(VEL_X), .VEL_Y(VEL_Y), .LOST(LOST), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0, tick_cnt = 0, frame_no = 0;
  always @(negedge CLK) if (FRAME_TICK) tick_cnt <= tick_cnt + 1;

  // reference model (frame level)
  int m_st, m_cx, m_cy, m_cnt, m_miss, m_tx, m_ty, m_vx, m_vy;
  int m_valid, m_lost, m_en, m_pend;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (frame %0d): got %0d expected %0d", tag, frame_no, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit m_near(input int ax, input int ay, input int bx, input int by, input int d);
    return (iabs(ax - bx) <= d) && (iabs(ay - by) <= d);
  endfunction

  task automatic model_reset();
    m_st = 0; m_cx = 0; m_cy = 0; m_cnt = 0; m_miss = 0;
    m_tx = 0; m_ty = 0; m_vx = 0; m_vy = 0;
    m_valid = 0; m_lost = 0; m_en = 0; m_pend = 0;
  endtask

  task automatic model_frame(input int x, input int y);
    bit is_miss;
    is_miss = (x == 0 && y == 0) || x > 39 || y > 29;
    m_lost = 0;
    m_en = m_en ^ m_pend;
    m_pend = 0;
    case (m_st)
      0: if (!is_miss) begin m_cx = x; m_cy = y; m_cnt = 1; m_st = 1; end
      1: begin
        if (is_miss) m_st = 0;
        else if (m_near(x, y, m_cx, m_cy, 4)) begin
          if (m_cnt + 1 == 3) begin
            m_st = 2; m_vx = x - m_cx; m_vy = y - m_cy; m_tx = x; m_ty = y; m_valid = 1;
          end else m_cnt++;
          m_cx = x; m_cy = y;
        end else begin m_cx = x; m_cy = y; m_cnt = 1; end
      end
      2: begin
        if (!is_miss && m_near(x, y, m_tx, m_ty, 4)) begin
          m_vx = x - m_tx; m_vy = y - m_ty; m_tx = x; m_ty = y;
        end else begin m_st = 3; m_miss = 1; end
      end
      default: begin
        if (!is_miss && m_near(x, y, m_tx, m_ty, 8)) begin
          m_st = 2; m_vx = x - m_tx; m_vy = y - m_ty; m_tx = x; m_ty = y; m_miss = 0;
        end else begin
          m_miss++;
          if (m_miss >= 8) begin
            m_st = 0; m_valid = 0; m_tx = 0; m_ty = 0; m_vx = 0; m_vy = 0; m_lost = 1; m_miss = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("state", int'(STATE), m_st);
    chk("track_valid", int'(TRACK_VALID), m_valid);
    chk("track_x", int'(TRACK_X), m_tx);
    chk("track_y", int'(TRACK_Y), m_ty);
    chk("vel_x", int'($signed(VEL_X)), m_vx);
    chk("vel_y", int'($signed(VEL_Y)), m_vy);
    chk("lost", int'(LOST), m_lost);
    chk("det_enable", int'(DET_ENABLE), m_en);
  endtask

  // One frame: present the ball, raise V to the boundary line, check at the tick.
  task automatic run_frame(input int x, input int y, input int hold, input bit align_press);
    int w;
    @(negedge CLK);
    BALL_X = 6'(x); BALL_Y = 6'(y); VGA_V_CNT = 13'd100;
    if (align_press) begin
      KEY_N = 1'b0;
      repeat (16) @(negedge CLK);
    end else repeat (3) @(negedge CLK);
    VGA_V_CNT = 13'(V_END);
    w = 0;
    do begin @(negedge CLK); w++; end while (!FRAME_TICK && w < 40);
    frame_no++;
    chk("tick_seen", int'(FRAME_TICK), 1);
    model_frame(x, y);
    if (align_press) m_pend = 1;
    check_outputs();
    @(negedge CLK);
    chk("tick_one_cycle", int'(FRAME_TICK), 0);
    chk("lost_one_cycle", int'(LOST), 0);
    repeat (hold) @(negedge CLK);
    VGA_V_CNT = 13'd0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, px, py, r, sx, sy;
    RST = 1'b1; VGA_V_CNT = 13'd0; VGA_H_CNT = 13'd0; BALL_X = 6'd0; BALL_Y = 6'd0; KEY_N = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_outputs();
    chk("reset_tick", int'(FRAME_TICK), 0);

    // acquisition: 0 -> 1 -> 1 -> 2
    run_frame(10, 5, 2, 0); chk("acq_state1", int'(STATE), 1);
    run_frame(11, 5, 2, 0); chk("acq_state2", int'(STATE), 1);
    run_frame(12, 6, 2, 0); chk("acq_state3", int'(STATE), 2);
    chk("acq_vel_x", int'($signed(VEL_X)), 1);
    chk("acq_vel_y", int'($signed(VEL_Y)), 1);
    run_frame(12, 6, 2, 0); chk("acq_vel_zero", int'($signed(VEL_X)), 0);

    // long boundary hold: exactly one tick per frame
    t0 = tick_cnt;
    for (int i = 0; i < 3; i++) run_frame(12, 6, 800, 0);
    repeat (2) @(negedge CLK);
    chk("tick_count_hold", tick_cnt - t0, 3);

    // jump out to COAST, then reacquire inside the wider window
    run_frame(16, 10, 1, 0);
    run_frame(20, 14, 1, 0);
    run_frame(20, 15, 1, 0);
    run_frame(30, 15, 1, 0); chk("coast_state", int'(STATE), 3);
    chk("coast_hold_x", int'(TRACK_X), 20);
    run_frame(27, 15, 1, 0); chk("reacq_vel_x", int'($signed(VEL_X)), 7);

    // eight misses drop the track
    for (int i = 0; i < 8; i++) run_frame(0, 0, 1, 0);
    chk("drop_state", int'(STATE), 0);

    // bouncy press mid-frame, applied only at the next tick
    @(negedge CLK); VGA_V_CNT = 13'd100;
    for (int i = 0; i < 5; i++) begin KEY_N = ~KEY_N; repeat (2) @(negedge CLK); end
    repeat (20) @(negedge CLK);
    m_pend = m_pend ^ 1;
    chk("en_before_tick", int'(DET_ENABLE), 0);
    KEY_N = 1'b1; repeat (22) @(negedge CLK);
    run_frame(0, 0, 1, 0); chk("en_flip", int'(DET_ENABLE), 1);

    // press accepted on the tick edge itself
    run_frame(0, 0, 1, 1); chk("en_align_hold", int'(DET_ENABLE), 1);
    @(negedge CLK); KEY_N = 1'b1; repeat (22) @(negedge CLK);
    run_frame(0, 0, 1, 0); chk("en_align_flip", int'(DET_ENABLE), 0);

    // reset while in CONFIRM
    run_frame(10, 5, 1, 0);
    run_frame(11, 5, 1, 0);
    @(negedge CLK); VGA_V_CNT = 13'd100; RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    check_outputs();
    run_frame(10, 5, 1, 0); chk("rst_state1", int'(STATE), 1);
    run_frame(10, 5, 1, 0); chk("rst_state2", int'(STATE), 1);
    run_frame(10, 5, 1, 0); chk("rst_state3", int'(STATE), 2);

    // random ball walk with misses, jumps and out-of-range samples
    px = 20; py = 15;
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) begin sx = 0; sy = 0; end
      else if (r < 18) begin sx = int'($urandom_range(40, 63)); sy = int'($urandom_range(0, 63)); end
      else begin
        if (r < 26) begin px = int'($urandom_range(1, 39)); py = int'($urandom_range(0, 29)); end
        else begin
          px += int'($urandom_range(0, 12)) - 6;
          py += int'($urandom_range(0, 12)) - 6;
          if (px < 0) px = 0; if (px > 39) px = 39;
          if (py < 0) py = 0; if (py > 29) py = 29;
        end
        sx = px; sy = py;
      end
      run_frame(sx, sy, int'($urandom_range(0, 4)), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ball_track_ctrl.md
Name: ball_track_ctrl

Overview:
Frame-level controller for the ball detector. Once per video frame it samples the detector's grid hotbox (BALL_X/BALL_Y, 40x30 grid) at end of active video. A SEARCH/CONFIRM/TRACK/COAST state machine qualifies the samples and publishes a validated track position and per-frame velocity to the game logic. It also owns the detector's ENABLE (debug overlay) line, which toggles from a push-button and changes only on frame boundaries.

Parameters:
V_END_LINE, 515, VGA_V_CNT value of the first line after active video (Y_START+480); frame boundary
MAX_JUMP, 4, max per-axis grid-cell change per frame accepted as the same ball
CONFIRM_FRAMES, 3, consecutive consistent detections needed to enter TRACK (range 2..15)
LOST_FRAMES, 8, consecutive misses in COAST before dropping the track (range 1..15)
DEBOUNCE_CYCLES, 500000, stable cycles required to accept a button level change (20-bit counter)
OVERLAY_DEFAULT, 0, DET_ENABLE value after reset

Ports:
CLK  in  1  pixel clock, same clock as the detector
RST  in  1  synchronous active-high reset
VGA_V_CNT  in  13  VGA line counter
VGA_H_CNT  in  13  VGA pixel counter (unused except for lint; framing uses V only)
BALL_X  in  6  detector hotbox column, 0..39
BALL_Y  in  6  detector hotbox row, 0..29
KEY_N  in  1  raw overlay push-button, active-low, asynchronous
DET_ENABLE  out  1  drives detector ENABLE
FRAME_TICK  out  1  one-cycle pulse per frame; marks the output update
TRACK_X  out  6  validated ball column
TRACK_Y  out  6  validated ball row
TRACK_VALID  out  1  high in TRACK and COAST
VEL_X  out  7  signed per-frame column delta, two's complement
VEL_Y  out  7  signed per-frame row delta
LOST  out  1  one-cycle pulse when the track is dropped
STATE  out  2  SEARCH=0, CONFIRM=1, TRACK=2, COAST=3 (debug)

Behaviour:
- Reset (RST high at a CLK edge): STATE=SEARCH, all outputs 0 except DET_ENABLE=OVERLAY_DEFAULT. Clears candidate, counters, pending toggle and sync/debounce state. Reset mid-frame discards that frame; the next boundary is handled normally.
- Frame boundary: registered flag eq = (VGA_V_CNT == V_END_LINE). Internal tick t = eq & ~eq_d, the rising edge, so exactly one per frame regardless of how long V holds. On the edge where t=1: BALL_X/BALL_Y are sampled, the FSM updates, and FRAME_TICK, TRACK_*, VEL_*, LOST, DET_ENABLE update together on that edge. FRAME_TICK is high exactly one cycle.
- Miss: a sample is a miss when it equals (0,0) or has X>39 or Y>29. "Near(a,b,d)": |ax-bx|<=d and |ay-by|<=d, computed on 7-bit unsigned differences, no wrap.
- SEARCH: miss -> stay. Hit -> cand=sample, cnt=1, go CONFIRM.
- CONFIRM: miss -> SEARCH. Hit and near(sample,cand,MAX_JUMP): cnt+1, cand=sample. If cnt+1==CONFIRM_FRAMES: go TRACK, TRACK=sample, VEL=sample-prev_cand, TRACK_VALID=1. Hit and not near: cand=sample, cnt=1, stay.
- TRACK: hit and near(sample,TRACK,MAX_JUMP): VEL=sample-TRACK, TRACK=sample, stay. Otherwise: go COAST, miss_cnt=1, TRACK and VEL held.
- COAST: hit and near(sample,TRACK,2*MAX_JUMP): go TRACK, VEL=sample-TRACK, TRACK=sample, miss_cnt=0. Otherwise miss_cnt+1. If it reaches LOST_FRAMES: go SEARCH, TRACK_VALID=0, TRACK=0, VEL=0, LOST=1 for that cycle. With LOST_FRAMES=1, the first COAST tick drops the track.
- VEL arithmetic: zero-extend both operands to 7 bits and subtract; range -39..+39, never saturates.
- Button: 2-FF synchroniser on KEY_N, then counter. It reloads on any level change and accepts the new level after DEBOUNCE_CYCLES stable cycles. A debounced press (1->0 on KEY_N) toggles the pending flag. On t=1, DET_ENABLE ^= pending and pending clears. A press accepted on the same edge as t is applied at the following frame. Two presses within one frame cancel out.
- No outputs change except at t edges, apart from LOST/FRAME_TICK deassertion and reset.

Test Plan:
- Reset, then 4 frames of BALL=(10,5),(11,5),(12,6),(12,6) with defaults -> STATE 0,1,1,2. After frame 3: TRACK=(12,6), VEL=(+1,+1), TRACK_VALID=1. After frame 4: VEL=(0,0).
- V_END_LINE held for 800 cycles, 3 frames -> exactly 3 FRAME_TICK pulses, each 1 cycle wide.
- In TRACK at (20,15), sample (30,15) -> COAST, TRACK holds (20,15). Next sample (27,15) (within 8) -> TRACK, VEL=(+7,0).
- In TRACK, 8 frames of (0,0) -> COAST, then SEARCH on the 8th tick: LOST pulse 1 cycle, TRACK_VALID=0, TRACK=(0,0).
- DEBOUNCE_CYCLES=16, KEY_N bounce 5 toggles in 10 cycles then low 20 cycles mid-frame -> DET_ENABLE flips 0->1 only at the next FRAME_TICK. A press landing on the tick edge flips it one frame later.
- Assert RST during CONFIRM (cnt=2), then present (10,5) for 3 frames -> STATE restarts at SEARCH and reaches TRACK on the 3rd frame.
